// File: rtl/trd_sched.sv
// Eight-thread fetch scheduler: thread lifecycle (spawn/kill/halt/resume) plus
// a round-robin fetch grant with a per-thread quantum.
module trd_sched #(
   parameter int unsigned QUANTUM = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       running,
   input  logic       spawn_req,
   input  logic [2:0] spawn_parent,
   output logic       spawn_ack,
   output logic [2:0] spawn_trd,
   input  logic       kill_req,
   input  logic [2:0] kill_trd,
   input  logic       alu_exp,
   input  logic [2:0] alu_trd,
   input  logic       inv_op,
   input  logic [2:0] inv_op_trd,
   input  logic       breakpoint,
   input  logic [2:0] bp_trd,
   input  logic       resume,
   input  logic [2:0] resume_trd,
   input  logic [7:0] stall,
   output logic [7:0] valid_trd,
   output logic [7:0] run_trd,
   output logic [7:0] halted_trd,
   output logic       fetch_vld,
   output logic [2:0] insfetch_trd,
   output logic       trd_full,
   output logic       trd_of
);

   localparam int unsigned NT = 8;
   localparam int unsigned TW = 3;
   localparam int unsigned CW = 4;

   logic [CW-1:0] q_cnt, q_cnt_n;
   logic [NT-1:0] valid_n, run_n, halted_n, ready, halt_ev, res_ev, kill_ev;
   logic          ack_n, of_n, fvld_n, parent_ok, found;
   logic [TW-1:0] sid_n, free_id, fid_n, idx;

   assign trd_full = &valid_trd;
   assign ready    = valid_trd & run_trd & ~stall;

   // Thread lifecycle: kill overrides halt, halt overrides resume, resume overrides spawn
   always_comb begin
      valid_n  = valid_trd;
      run_n    = run_trd;
      halted_n = halted_trd;
      ack_n    = 1'b0;
      sid_n    = '0;
      of_n     = 1'b0;
      free_id  = '0;

      kill_ev = {NT{kill_req}} & (NT'(1) << kill_trd);
      halt_ev = (({NT{alu_exp}}    & (NT'(1) << alu_trd))
               | ({NT{inv_op}}     & (NT'(1) << inv_op_trd))
               | ({NT{breakpoint}} & (NT'(1) << bp_trd))) & valid_trd;
      res_ev  = {NT{resume}} & (NT'(1) << resume_trd) & valid_trd & halted_trd & ~halt_ev;

      run_n    = (run_n & ~halt_ev) | res_ev;
      halted_n = (halted_n | halt_ev) & ~res_ev;

      for (int i = NT - 1; i >= 0; i--) begin
         if (!valid_trd[i]) free_id = TW'(i);
      end

      // Allocation sees this cycle's valid set, so a slot being killed now is not reusable yet
      parent_ok = spawn_req & valid_trd[spawn_parent];
      if (parent_ok && trd_full) begin
         of_n = 1'b1;
      end else if (parent_ok && !kill_ev[free_id]) begin
         valid_n[free_id]  = 1'b1;
         run_n[free_id]    = 1'b1;
         halted_n[free_id] = 1'b0;
         ack_n             = 1'b1;
         sid_n             = free_id;
      end

      valid_n  = valid_n & ~kill_ev;
      run_n    = run_n & ~kill_ev;
      halted_n = halted_n & ~kill_ev;
   end

   // Round-robin grant; the current thread is the last candidate of the search
   always_comb begin
      fvld_n  = 1'b0;
      fid_n   = insfetch_trd;
      q_cnt_n = '0;
      found   = 1'b0;
      idx     = '0;
      if (running && (|ready)) begin
         if (fetch_vld && ready[insfetch_trd] && (q_cnt < CW'(QUANTUM))) begin
            fvld_n  = 1'b1;
            q_cnt_n = q_cnt + CW'(1);
         end else begin
            for (int unsigned i = 1; i <= NT; i++) begin
               idx = TW'(insfetch_trd + i);
               if (!found && ready[idx]) begin
                  found = 1'b1;
                  fid_n = idx;
               end
            end
            fvld_n  = 1'b1;
            q_cnt_n = CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_trd    <= 8'h01;
         run_trd      <= 8'h01;
         halted_trd   <= '0;
         spawn_ack    <= 1'b0;
         spawn_trd    <= '0;
         trd_of       <= 1'b0;
         fetch_vld    <= 1'b0;
         insfetch_trd <= 3'd7;
         q_cnt        <= '0;
      end else begin
         valid_trd    <= valid_n;
         run_trd      <= run_n;
         halted_trd   <= halted_n;
         spawn_ack    <= ack_n;
         spawn_trd    <= sid_n;
         trd_of       <= of_n;
         fetch_vld    <= fvld_n;
         insfetch_trd <= fid_n;
         q_cnt        <= q_cnt_n;
      end
   end

endmodule

// File: tb/tb_trd_sched.sv
// Bench for trd_sched: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_trd_sched;

   localparam int unsigned Q = 3;

   logic       clk, rst_n, running;
   logic       spawn_req, kill_req, alu_exp, inv_op, breakpoint, resume;
   logic [2:0] spawn_parent, kill_trd, alu_trd, inv_op_trd, bp_trd, resume_trd;
   logic [7:0] stall;
   logic       spawn_ack, fetch_vld, trd_full, trd_of;
   logic [2:0] spawn_trd, insfetch_trd;
   logic [7:0] valid_trd, run_trd, halted_trd;

   int n_vec = 0;
   int n_err = 0;

   trd_sched #(.QUANTUM(Q)) dut (
      .clk(clk), .rst_n(rst_n), .running(running),
      .spawn_req(spawn_req), .spawn_parent(spawn_parent),
      .spawn_ack(spawn_ack), .spawn_trd(spawn_trd),
      .kill_req(kill_req), .kill_trd(kill_trd),
      .alu_exp(alu_exp), .alu_trd(alu_trd),
      .inv_op(inv_op), .inv_op_trd(inv_op_trd),
      .breakpoint(breakpoint), .bp_trd(bp_trd),
      .resume(resume), .resume_trd(resume_trd),
      .stall(stall),
      .valid_trd(valid_trd), .run_trd(run_trd), .halted_trd(halted_trd),
      .fetch_vld(fetch_vld), .insfetch_trd(insfetch_trd),
      .trd_full(trd_full), .trd_of(trd_of)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: per-thread flags, grant owner and how many cycles it has held the slot
   bit [7:0] mv, mr, mh, nv, nr, nh;
   bit       mfv, nfv, mack, nack, mof, nof;
   bit [2:0] mcur, ncur, mid, nid;
   int       mused, nused;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mv = 8'h01; mr = 8'h01; mh = 8'h00;
      mfv = 1'b0; mcur = 3'd7; mused = 0;
      mack = 1'b0; mid = 3'd0; mof = 1'b0;
   endtask

   task automatic model_step();
      bit       k, h, r;
      bit [7:0] rdy;
      int       free;
      nv = mv; nr = mr; nh = mh;
      nack = 1'b0; nid = 3'd0; nof = 1'b0;
      for (int t = 0; t < 8; t++) begin
         k = kill_req && (kill_trd == 3'(t));
         h = (alu_exp && alu_trd == 3'(t)) || (inv_op && inv_op_trd == 3'(t))
             || (breakpoint && bp_trd == 3'(t));
         r = resume && (resume_trd == 3'(t));
         if (k) begin
            nv[t] = 1'b0; nr[t] = 1'b0; nh[t] = 1'b0;
         end else if (mv[t] && h) begin
            nr[t] = 1'b0; nh[t] = 1'b1;
         end else if (mv[t] && mh[t] && r) begin
            nr[t] = 1'b1; nh[t] = 1'b0;
         end
      end
      if (spawn_req && mv[spawn_parent]) begin
         if (mv == 8'hFF) nof = 1'b1;
         else begin
            free = 8;
            for (int t = 7; t >= 0; t--) if (!mv[t]) free = t;
            if (!(kill_req && kill_trd == 3'(free))) begin
               nv[free] = 1'b1; nr[free] = 1'b1; nh[free] = 1'b0;
               nack = 1'b1; nid = 3'(free);
            end
         end
      end
      rdy = mv & mr & ~stall;
      ncur = mcur; nfv = 1'b0; nused = 0;
      if (running && rdy != 8'h00) begin
         nfv = 1'b1;
         if (mfv && rdy[mcur] && mused < int'(Q)) begin
            nused = mused + 1;
         end else begin
            nused = 1;
            for (int s = 8; s >= 1; s--)
               if (rdy[(int'(mcur) + s) % 8]) ncur = 3'((int'(mcur) + s) % 8);
         end
      end
   endtask

   task automatic model_commit();
      mv = nv; mr = nr; mh = nh; mfv = nfv; mcur = ncur; mused = nused;
      mack = nack; mid = nid; mof = nof;
   endtask

   task automatic check_model();
      chk("valid_trd",    valid_trd,        mv);
      chk("run_trd",      run_trd,          mr);
      chk("halted_trd",   halted_trd,       mh);
      chk("fetch_vld",    8'(fetch_vld),    8'(mfv));
      if (mfv) chk("insfetch_trd", 8'(insfetch_trd), 8'(mcur));
      chk("spawn_ack",    8'(spawn_ack),    8'(mack));
      chk("spawn_trd",    8'(spawn_trd),    8'(mid));
      chk("trd_of",       8'(trd_of),       8'(mof));
      chk("trd_full",     8'(trd_full),     8'(mv == 8'hFF));
   endtask

   task automatic idle_inputs();
      spawn_req = 0; kill_req = 0; alu_exp = 0; inv_op = 0; breakpoint = 0; resume = 0;
      spawn_parent = 0; kill_trd = 0; alu_trd = 0; inv_op_trd = 0; bp_trd = 0;
      resume_trd = 0; stall = 8'h00;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      model_commit();
      @(negedge clk);
      check_model();
   endtask

   task automatic spawn_from(input logic [2:0] p);
      spawn_req = 1'b1; spawn_parent = p;
      cycle();
      idle_inputs();
   endtask

   task automatic reset_pulse(input logic with_spawn);
      spawn_req = with_spawn; spawn_parent = 3'd0;
      #2 rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check_model();
      rst_n = 1'b1;
      idle_inputs();
   endtask

   initial begin
      rst_n = 1'b0; running = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      check_model();
      chk("rst_valid",  valid_trd,          8'h01);
      chk("rst_run",    run_trd,            8'h01);
      chk("rst_halted", halted_trd,         8'h00);
      chk("rst_fvld",   8'(fetch_vld),      8'd0);
      chk("rst_fid",    8'(insfetch_trd),   8'd7);
      chk("rst_ack",    8'(spawn_ack),      8'd0);
      rst_n = 1'b1;

      // First grant plus three spawns from thread 0 (quantum 3)
      running = 1'b1;
      spawn_from(3'd0);
      chk("first_fvld", 8'(fetch_vld), 8'd1);
      chk("first_fid",  8'(insfetch_trd), 8'd0);
      chk("spawn1", 8'(spawn_trd), 8'd1);
      spawn_from(3'd0);
      chk("spawn2", 8'(spawn_trd), 8'd2);
      chk("q_hold0", 8'(insfetch_trd), 8'd0);
      spawn_from(3'd0);
      chk("spawn3", 8'(spawn_trd), 8'd3);
      cycle();
      chk("q_rot1", 8'(insfetch_trd), 8'd1);
      chk("no_ack", 8'(spawn_ack), 8'd0);
      stall = 8'h02;
      cycle();
      idle_inputs();
      chk("stall_rot2", 8'(insfetch_trd), 8'd2);

      // Fill, overflow, kill-then-spawn reuse
      for (int i = 4; i < 8; i++) spawn_from(3'd0);
      chk("spawn7", 8'(spawn_trd), 8'd7);
      chk("full", 8'(trd_full), 8'd1);
      kill_req = 1'b1; kill_trd = 3'd5;
      spawn_from(3'd3);
      chk("of_pulse", 8'(trd_of), 8'd1);
      chk("of_noack", 8'(spawn_ack), 8'd0);
      chk("kill5", valid_trd, 8'hDF);
      spawn_from(3'd3);
      chk("of_clear", 8'(trd_of), 8'd0);
      chk("reuse5", 8'(spawn_trd), 8'd5);

      // Halt beats resume on the same thread; later resume clears it
      breakpoint = 1'b1; bp_trd = 3'd2; resume = 1'b1; resume_trd = 3'd2;
      cycle();
      idle_inputs();
      chk("bp_run2",  8'(run_trd[2]), 8'd0);
      chk("bp_halt2", 8'(halted_trd[2]), 8'd1);
      resume = 1'b1; resume_trd = 3'd2;
      cycle();
      idle_inputs();
      chk("res_run2", 8'(run_trd[2]), 8'd1);
      chk("res_halt2", 8'(halted_trd[2]), 8'd0);

      // Kill beats halt
      kill_req = 1'b1; kill_trd = 3'd4; alu_exp = 1'b1; alu_trd = 3'd4;
      cycle();
      idle_inputs();
      chk("kill4_valid", 8'(valid_trd[4]), 8'd0);
      chk("kill4_halt",  8'(halted_trd[4]), 8'd0);

      // Reset during a spawn request leaves no ack behind
      reset_pulse(1'b1);
      cycle();
      chk("rst_abort_ack", 8'(spawn_ack), 8'd0);
      chk("rst_abort_valid", valid_trd, 8'h01);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(399) == 0) begin
            reset_pulse(1'b0);
         end
         running      = ($urandom_range(15) != 0);
         spawn_req    = ($urandom_range(2) == 0);
         spawn_parent = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom_range(7));
         kill_req     = ($urandom_range(9) == 0);
         kill_trd     = 3'($urandom_range(7));
         alu_exp      = ($urandom_range(11) == 0);
         alu_trd      = 3'($urandom_range(7));
         inv_op       = ($urandom_range(11) == 0);
         inv_op_trd   = 3'($urandom_range(7));
         breakpoint   = ($urandom_range(11) == 0);
         bp_trd       = 3'($urandom_range(7));
         resume       = ($urandom_range(3) == 0);
         resume_trd   = 3'($urandom_range(7));
         stall        = 8'($urandom & $urandom & $urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
